dfp_addsub_iter: RTL and testbench
==================================

Name: dfp_addsub_iter

Overview:
- Parametrised, handshaked decimal floating-point add/subtract core on unpacked BCD operands.
- Successor to the fixed 96-bit pipelined adder, generalised in digit count and exponent width.
- Alignment is iterative, one BCD digit per cycle, so area does not grow with a barrel shifter.
- Produces an unnormalised result for the existing normalise/round stages.
- Adds valid/ready flow control and optional sticky tracking.

Parameters:
- N, 25, significand digits (BCD, 4 bits each).
- EXPW, 12, exponent width.
- XINF, 12'hBFF, exponent value flagging infinity on input; driven on infinity output.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; when low all state and outputs hold
- req_valid  in  1  operands valid
- req_ready  out  1  core can accept operands
- rm  in  3  rounding mode (3 = round down)
- op  in  1  0 add, 1 subtract
- a_sign, b_sign  in  1  operand signs
- a_exp, b_exp  in  EXPW  operand exponents
- a_sig, b_sig  in  N*4  BCD significands
- a_nan, b_nan, a_inf, b_inf  in  1  operand class flags
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- o_sign  out  1  result sign
- o_exp  out  EXPW  result exponent
- o_sig  out  (N+2)*4  {carry digit, N digits, guard digit}
- o_nan, o_qnan, o_inf  out  1  result class flags

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. Reset has priority over ce.
- Reset:
  - State returns to IDLE.
  - res_valid = 0. All result outputs = 0.
  - req_ready = 0 while rst is high, then 1 in IDLE.
  - Reset mid-operation abandons the operation; no res_valid is produced.
- req_ready = (state == IDLE).
- Accept occurs on a ce cycle with req_valid & req_ready. At accept, register:
  - effective op = op ^ a_sign ^ b_sign
  - operands
  - rm
  - larger exponent
  - k = min(|a_exp - b_exp|, N+1)
- The smaller-exponent significand is loaded into an (N+1)-digit shift register {sig, 0}.
- ALIGN state:
  - Each ce cycle: shift right one digit and decrement k; the shifted-out digit is ORed into sticky.
  - Exit when k reaches 0. If k = 0 at accept, skip ALIGN and go straight to CMP.
- CMP, 1 cycle:
  - Compare the aligned magnitudes as {sig, guard}.
  - Order the operands larger/smaller.
  - Compute resZero = effective subtract with equal aligned values and sticky = 0, or both operands zero.
- ARITH, 1 cycle:
  - BCD add (carry goes into the carry digit), or BCD subtract larger minus smaller (never negative).
- DONE:
  - res_valid = 1; outputs stable until res_ready.
  - On res_valid & res_ready & ce: go to IDLE, and res_valid drops next cycle.
- Latency: res_valid is high k+3 cycles after the accept edge (ce-cycles). Throughput is one result per k+4 cycles minimum.
- Sign:
  - Add: sign of a.
  - Subtract: sign of the larger-magnitude operand, with b's sign inverted when op = 1.
  - resZero: sign = (rm == 3), except when both operands are negative for an effective add, which gives sign 1.
- Exponent: larger exponent; 0 when resZero.
- Special cases (priority order; these still pass through the FSM with identical latency):
  1. a_inf & b_inf:
     - Effective subtract gives o_qnan = 1, o_nan = 1, o_sig = {4'h9, 0...}.
     - Effective add gives o_inf = 1, o_exp = XINF.
  2. a_nan: o_nan = 1, o_sig = {0, a_sig, 0}.
  3. b_nan: o_nan = 1, o_sig = {0, b_sig, 0}.
  4. Single inf: o_inf = 1, o_exp = XINF, o_sig = 0, sign of the infinite operand (b inverted on subtract).
- Input exponents equal to XINF without an inf flag are treated as numbers.

Optional Feature:
- DFPADDSUB_STICKY_EN.
- Defined: sticky accumulates the OR of all digits shifted out in ALIGN. It is ORed into bit 0 of the guard digit before ARITH.
- Undefined: sticky logic is removed. Shifted-out digits are discarded. The guard digit holds only the last digit shifted into it.

Test Plan:
- N=4, EXPW=8, a=16'h1234, b=16'h0766, both exp 8'h40, op=0 -> o_sig 24'h020000, o_exp 8'h40, o_sign 0, res_valid 3 cycles after accept.
- a=16'h0100 exp 8'h41, b=16'h0001 exp 8'h40, op=1 -> k=1, o_sig 24'h000999, o_exp 8'h41, o_sign 0, res_valid at 4 cycles.
- a=b=16'h1234, exp 8'h40, op=1: rm=3 -> o_sig 0, o_exp 0, o_sign 1; rm=0 -> o_sign 0.
- a=16'h1000 exp 8'h46, b=16'h1234 exp 8'h40, op=0 -> k=5:
  - STICKY_EN: o_sig 24'h010001.
  - Without: o_sig 24'h010000.
  - res_valid at 8 cycles.
- a_inf=b_inf=1, same sign, op=1 -> o_qnan=1, o_nan=1, o_inf=0; with op=0 -> o_inf=1, o_exp=XINF.
- Backpressure and reset:
  - Hold res_ready=0 for 5 cycles -> outputs stable, req_ready=0, second request not accepted.
  - Assert rst during ALIGN -> next cycle state IDLE, res_valid never asserts for that operation.

Source files
------------

// File: rtl/dfp_addsub_iter.sv
// dfp_addsub_iter: handshaked BCD decimal floating-point add/subtract with digit-serial alignment.
// The result is unnormalised ({carry, N digits, guard}) and is meant for the normalise/round stages.
// Build option DFPADDSUB_STICKY_EN keeps a sticky bit over the digits lost during alignment.
module dfp_addsub_iter #(
    parameter int              N    = 25,
    parameter int              EXPW = 12,
    parameter logic [EXPW-1:0] XINF = 12'hBFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           rm,
    input  logic                 op,
    input  logic                 a_sign,
    input  logic                 b_sign,
    input  logic [EXPW-1:0]      a_exp,
    input  logic [EXPW-1:0]      b_exp,
    input  logic [N*4-1:0]       a_sig,
    input  logic [N*4-1:0]       b_sig,
    input  logic                 a_nan,
    input  logic                 b_nan,
    input  logic                 a_inf,
    input  logic                 b_inf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 o_sign,
    output logic [EXPW-1:0]      o_exp,
    output logic [(N+2)*4-1:0]   o_sig,
    output logic                 o_nan,
    output logic                 o_qnan,
    output logic                 o_inf
);
    localparam int KW = $clog2(N + 2);
    localparam int SW = (N + 1) * 4;

    typedef enum logic [2:0] {IDLE, ALIGN, CMP, ARITH, DONE} state_t;

    state_t          r_state;
    logic            r_eop, r_a_sign, r_b_sign, r_swap, r_zab, r_zero, r_sgn;
    logic            r_a_nan, r_b_nan, r_a_inf, r_b_inf;
    logic [2:0]      r_rm;
    logic [EXPW-1:0] r_exp;
    logic [KW-1:0]   r_k;
    logic [SW-1:0]   r_fix, r_sh, r_big, r_small;
    logic [N*4-1:0]  r_pay;
    logic [EXPW-1:0] w_diff;
    logic [KW-1:0]   w_k;
    logic            w_swap, w_stk, w_ge, w_c, w_bw;
    logic [SW-1:0]   w_sm, w_sum, w_dif;
    logic [4:0]      w_ts, w_td;
`ifdef DFPADDSUB_STICKY_EN
    logic            r_stk;
    assign w_stk = r_stk;
`else
    assign w_stk = 1'b0;
`endif

    // the shifted operand with sticky folded into the lsb of its guard digit
    assign w_sm      = {r_sh[SW-1:1], r_sh[0] | w_stk};
    assign w_ge      = r_fix >= w_sm;
    assign req_ready = (r_state == IDLE) && !rst;

    // exponent distance, clamped so alignment never exceeds N+1 digit shifts
    always_comb begin
        w_swap = b_exp > a_exp;
        w_diff = w_swap ? b_exp - a_exp : a_exp - b_exp;
        w_k    = (w_diff > EXPW'(N + 1)) ? KW'(N + 1) : KW'(w_diff);
    end

    // digit-wise BCD sum and larger-minus-smaller difference of the ordered operands
    always_comb begin
        w_c   = 1'b0;
        w_bw  = 1'b0;
        w_ts  = '0;
        w_td  = '0;
        w_sum = '0;
        w_dif = '0;
        for (int i = 0; i < N + 1; i++) begin
            w_ts = {1'b0, r_big[i*4 +: 4]} + {1'b0, r_small[i*4 +: 4]} + {4'b0, w_c};
            w_c = w_ts > 5'd9;
            w_sum[i*4 +: 4] = w_c ? w_ts[3:0] + 4'd6 : w_ts[3:0];
            w_td = {1'b0, r_big[i*4 +: 4]} - {1'b0, r_small[i*4 +: 4]} - {4'b0, w_bw};
            w_bw = w_td[4];
            w_dif[i*4 +: 4] = w_bw ? w_td[3:0] + 4'd10 : w_td[3:0];
        end
    end

    // control FSM, operand datapath and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            res_valid <= 1'b0;
            o_sign    <= 1'b0;
            o_exp     <= '0;
            o_sig     <= '0;
            o_nan     <= 1'b0;
            o_qnan    <= 1'b0;
            o_inf     <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_state  <= (w_k == '0) ? CMP : ALIGN;
                    r_eop    <= op ^ a_sign ^ b_sign;
                    r_a_sign <= a_sign;
                    r_b_sign <= b_sign ^ op;
                    r_rm     <= rm;
                    r_swap   <= w_swap;
                    r_exp    <= w_swap ? b_exp : a_exp;
                    r_k      <= w_k;
                    r_fix    <= {w_swap ? b_sig : a_sig, 4'h0};
                    r_sh     <= {w_swap ? a_sig : b_sig, 4'h0};
                    r_zab    <= (a_sig == '0) && (b_sig == '0);
                    r_pay    <= a_nan ? a_sig : b_sig;
                    r_a_nan  <= a_nan;
                    r_b_nan  <= b_nan;
                    r_a_inf  <= a_inf;
                    r_b_inf  <= b_inf;
`ifdef DFPADDSUB_STICKY_EN
                    r_stk    <= 1'b0;
`endif
                end
                ALIGN: begin
                    r_sh <= {4'h0, r_sh[SW-1:4]};
                    r_k  <= r_k - KW'(1);
`ifdef DFPADDSUB_STICKY_EN
                    r_stk <= r_stk | (r_sh[3:0] != 4'h0);
`endif
                    if (r_k == KW'(1)) r_state <= CMP;
                end
                CMP: begin
                    r_big   <= w_ge ? r_fix : w_sm;
                    r_small <= w_ge ? w_sm : r_fix;
                    r_sgn   <= (!r_eop || (w_ge ^ r_swap)) ? r_a_sign : r_b_sign;
                    r_zero  <= (r_eop && (r_fix == w_sm) && !w_stk) || r_zab;
                    r_state <= ARITH;
                end
                ARITH: begin
                    r_state   <= DONE;
                    res_valid <= 1'b1;
                    o_nan     <= 1'b0;
                    o_qnan    <= 1'b0;
                    o_inf     <= 1'b0;
                    if (r_a_inf && r_b_inf) begin
                        o_nan  <= r_eop;
                        o_qnan <= r_eop;
                        o_inf  <= !r_eop;
                        o_sign <= r_a_sign & !r_eop;
                        o_exp  <= r_eop ? '0 : XINF;
                        o_sig  <= r_eop ? {4'h9, SW'(0)} : '0;
                    end else if (r_a_nan || r_b_nan) begin
                        o_nan  <= 1'b1;
                        o_sign <= r_a_nan ? r_a_sign : r_b_sign;
                        o_exp  <= r_exp;
                        o_sig  <= {4'h0, r_pay, 4'h0};
                    end else if (r_a_inf || r_b_inf) begin
                        o_inf  <= 1'b1;
                        o_sign <= r_a_inf ? r_a_sign : r_b_sign;
                        o_exp  <= XINF;
                        o_sig  <= '0;
                    end else begin
                        o_sign <= r_zero ? (r_rm == 3'd3) || (r_a_sign && r_b_sign && !r_eop) : r_sgn;
                        o_exp  <= r_zero ? '0 : r_exp;
                        o_sig  <= r_eop ? {4'h0, w_dif} : {3'h0, w_c, w_sum};
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dfp_addsub_iter.sv
// tb_dfp_addsub_iter: directed vectors against a value-level decimal model of dfp_addsub_iter.
`timescale 1ns/1ps
module tb_dfp_addsub_iter;
    localparam int         N    = 4;
    localparam int         EXPW = 8;
    localparam logic [7:0] XINF = 8'hBF;
`ifdef DFPADDSUB_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, req_valid, req_ready, op, a_sign, b_sign;
    logic        a_nan, b_nan, a_inf, b_inf, res_valid, res_ready;
    logic        o_sign, o_nan, o_qnan, o_inf;
    logic [2:0]  rm;
    logic [7:0]  a_exp, b_exp, o_exp;
    logic [15:0] a_sig, b_sig;
    logic [23:0] o_sig;

    int total = 0;
    int bad = 0;

    logic        e_sign, e_nan, e_qnan, e_inf;
    logic        ck_sign, ck_exp, ck_sig, ck_qnan;
    logic [7:0]  e_exp;
    logic [23:0] e_sig;

    dfp_addsub_iter #(.N(N), .EXPW(EXPW), .XINF(XINF)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_ready(req_ready),
        .rm(rm), .op(op), .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
        .a_sig(a_sig), .b_sig(b_sig), .a_nan(a_nan), .b_nan(b_nan), .a_inf(a_inf), .b_inf(b_inf),
        .res_valid(res_valid), .res_ready(res_ready), .o_sign(o_sign), .o_exp(o_exp),
        .o_sig(o_sig), .o_nan(o_nan), .o_qnan(o_qnan), .o_inf(o_inf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic longint bcd2int(input logic [15:0] s);
        longint v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + longint'(s[i*4 +: 4]);
        return v;
    endfunction

    function automatic logic [23:0] int2bcd(input longint v);
        logic [23:0] r = '0;
        longint t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // value-level reference: align by integer division by 10^k, then add or subtract magnitudes
    task automatic model(input logic as_, bs, op_, input logic [2:0] rm_, input logic [7:0] ae, be,
                         input logic [15:0] asg, bsg, input logic an, bn, ai, bi);
        longint av, bv, fix, sm, p, aal, bal, r;
        int k;
        logic eop, bse, swap, stk, zero;
        av = bcd2int(asg);
        bv = bcd2int(bsg);
        eop = op_ ^ as_ ^ bs;
        bse = bs ^ op_;
        swap = be > ae;
        k = swap ? int'(be) - int'(ae) : int'(ae) - int'(be);
        if (k > N + 1) k = N + 1;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        fix = (swap ? bv : av) * 10;
        sm = (swap ? av : bv) * 10;
        stk = (sm % p) != 0;
        sm = sm / p;
        if (STK) begin
            if (stk && (sm % 2 == 0)) sm = sm + 1;
        end else stk = 1'b0;
        aal = swap ? sm : fix;
        bal = swap ? fix : sm;
        zero = (eop && aal == bal && !stk) || (av == 0 && bv == 0);
        r = !eop ? aal + bal : (aal >= bal ? aal - bal : bal - aal);
        e_sig = int2bcd(r);
        e_exp = zero ? 8'h00 : (swap ? be : ae);
        e_sign = zero ? ((rm_ == 3'd3) || (as_ && bse && !eop)) : (!eop ? as_ : (aal > bal ? as_ : bse));
        e_nan = 1'b0; e_qnan = 1'b0; e_inf = 1'b0;
        ck_sign = 1'b1; ck_exp = 1'b1; ck_sig = 1'b1; ck_qnan = 1'b1;
        if (ai && bi) begin
            ck_sign = 1'b0;
            if (eop) begin
                e_nan = 1'b1; e_qnan = 1'b1; e_sig = 24'h900000; ck_exp = 1'b0;
            end else begin
                e_inf = 1'b1; e_exp = XINF; ck_sig = 1'b0;
            end
        end else if (an || bn) begin
            e_nan = 1'b1; e_sig = {4'h0, an ? asg : bsg, 4'h0};
            ck_sign = 1'b0; ck_exp = 1'b0; ck_qnan = 1'b0;
        end else if (ai || bi) begin
            e_inf = 1'b1; e_exp = XINF; e_sig = 24'h0; e_sign = ai ? as_ : bse;
        end
    endtask

    // every cycle a result is presented it must match the model
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (ck_sig) check("sig", 32'(o_sig), 32'(e_sig));
            if (ck_exp) check("exp", 32'(o_exp), 32'(e_exp));
            if (ck_sign) check("sign", 32'(o_sign), 32'(e_sign));
            if (ck_qnan) check("qnan", 32'(o_qnan), 32'(e_qnan));
            check("nan", 32'(o_nan), 32'(e_nan));
            check("inf", 32'(o_inf), 32'(e_inf));
        end
    end

    task automatic run(input logic as_, bs, op_, input logic [2:0] rm_, input logic [7:0] ae, be,
                       input logic [15:0] asg, bsg, input logic an, bn, ai, bi,
                       input logic lchk, input logic [23:0] lit, input int lat_exp,
                       input int hold, input int gap);
        int n, lat;
        model(as_, bs, op_, rm_, ae, be, asg, bsg, an, bn, ai, bi);
        @(negedge clk);
        a_sign = as_; b_sign = bs; op = op_; rm = rm_; a_exp = ae; b_exp = be;
        a_sig = asg; b_sig = bsg; a_nan = an; b_nan = bn; a_inf = ai; b_inf = bi;
        res_ready = (hold == 0);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (gap > 0) begin
            ce = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
            check("ce_hold_valid", 32'(res_valid), 32'd0);
            check("ce_hold_ready", 32'(req_ready), 32'd0);
            ce = 1'b1;
        end
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 32'(lat), 32'(lat_exp));
        if (lchk) begin
            check("model_pin", 32'(e_sig), 32'(lit));
            check("lit_sig", 32'(o_sig), 32'(lit));
        end
        if (hold > 0) begin
            req_valid = 1'b1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("bp_valid", 32'(res_valid), 32'd1);
                check("bp_ready", 32'(req_ready), 32'd0);
            end
            @(negedge clk);
            req_valid = 1'b0;
            res_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check("valid_drop", 32'(res_valid), 32'd0);
        check("ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst = 1'b1; ce = 1'b1; req_valid = 1'b0; res_ready = 1'b1; op = 1'b0; rm = 3'd0;
        a_sign = 1'b0; b_sign = 1'b0; a_exp = '0; b_exp = '0; a_sig = '0; b_sig = '0;
        a_nan = 1'b0; b_nan = 1'b0; a_inf = 1'b0; b_inf = 1'b0;
        e_sign = 1'b0; e_nan = 1'b0; e_qnan = 1'b0; e_inf = 1'b0; e_exp = '0; e_sig = '0;
        ck_sign = 1'b1; ck_exp = 1'b1; ck_sig = 1'b1; ck_qnan = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_sig", 32'(o_sig), 32'd0);
        check("rst_exp", 32'(o_exp), 32'd0);
        check("rst_flags", 32'({o_sign, o_nan, o_qnan, o_inf}), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("idle_ready", 32'(req_ready), 32'd1);

        run(0, 0, 0, 3'd0, 8'h40, 8'h40, 16'h1234, 16'h0766, 0, 0, 0, 0, 1, 24'h020000, 3, 0, 0);
        run(0, 0, 1, 3'd0, 8'h41, 8'h40, 16'h0100, 16'h0001, 0, 0, 0, 0, 1, 24'h000999, 4, 0, 0);
        run(0, 0, 1, 3'd3, 8'h40, 8'h40, 16'h1234, 16'h1234, 0, 0, 0, 0, 1, 24'h000000, 3, 0, 0);
        run(0, 0, 1, 3'd0, 8'h40, 8'h40, 16'h1234, 16'h1234, 0, 0, 0, 0, 1, 24'h000000, 3, 0, 0);
        run(0, 0, 0, 3'd0, 8'h46, 8'h40, 16'h1000, 16'h1234, 0, 0, 0, 0, 1,
            STK ? 24'h010001 : 24'h010000, 8, 0, 0);
        run(0, 0, 1, 3'd0, XINF, XINF, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 24'h900000, 3, 0, 0);
        run(0, 0, 0, 3'd0, XINF, XINF, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 24'h000000, 3, 0, 0);
        run(0, 0, 1, 3'd0, 8'h40, 8'h40, 16'h0001, 16'h0500, 0, 0, 0, 0, 1, 24'h004990, 3, 0, 0);
        run(1, 1, 0, 3'd0, 8'h40, 8'h42, 16'h0005, 16'h0123, 0, 0, 0, 0, 1,
            STK ? 24'h001231 : 24'h001230, 5, 0, 0);
        run(0, 1, 0, 3'd0, 8'h40, 8'h40, 16'h0321, 16'h0000, 1, 0, 0, 0, 1, 24'h003210, 3, 0, 0);
        run(0, 0, 0, 3'd0, 8'h40, 8'h40, 16'h0000, 16'h0456, 0, 1, 0, 0, 1, 24'h004560, 3, 0, 0);
        run(0, 0, 1, 3'd0, 8'h40, XINF, 16'h0042, 16'h0000, 0, 0, 0, 1, 1, 24'h000000, 8, 0, 0);
        run(1, 1, 0, 3'd0, 8'h30, 8'h20, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 24'h000000, 8, 0, 0);
        run(0, 0, 1, 3'd0, 8'h90, 8'h40, 16'h0001, 16'h9999, 0, 0, 0, 0, 1,
            STK ? 24'h000009 : 24'h000010, 8, 0, 0);
        run(0, 0, 0, 3'd0, XINF, XINF, 16'h0002, 16'h0003, 0, 0, 0, 0, 1, 24'h000050, 3, 0, 0);
        run(0, 1, 0, 3'd0, 8'h40, 8'h40, 16'h0500, 16'h0200, 0, 0, 0, 0, 1, 24'h003000, 3, 5, 0);
        run(0, 0, 1, 3'd0, 8'h41, 8'h40, 16'h0100, 16'h0001, 0, 0, 0, 0, 1, 24'h000999, 4, 0, 3);

        @(negedge clk);
        a_sign = 0; b_sign = 0; op = 0; a_exp = 8'h46; b_exp = 8'h40; a_sig = 16'h1000; b_sig = 16'h1234;
        a_nan = 0; b_nan = 0; a_inf = 0; b_inf = 0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_ready", 32'(req_ready), 32'd0);
        check("mrst_valid", 32'(res_valid), 32'd0);
        check("mrst_sig", 32'(o_sig), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("mrst_idle", 32'(req_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1 seen = seen | res_valid;
        end
        check("mrst_abandon", 32'(seen), 32'd0);

        run(0, 0, 0, 3'd0, 8'h40, 8'h40, 16'h1234, 16'h0766, 0, 0, 0, 0, 1, 24'h020000, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
